// File: rtl/digit_entry.sv
// Four debounced pushbuttons driving a single hex digit: clear, load, increment, decrement.
// Each key has its own synchronizer and four-state debounce FSM; actions are applied one cycle after a press pulse.
module digit_entry #(
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_n,
    input  logic [3:0] sw,
    output logic [3:0] number,
    output logic       changed,
    output logic [3:0] key_level
);

    localparam logic [1:0]  ST_RELEASED     = 2'd0;
    localparam logic [1:0]  ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0]  ST_PRESSED      = 2'd2;
    localparam logic [1:0]  ST_RELEASE_WAIT = 2'd3;
    localparam logic [19:0] DB_LIMIT        = 20'(DEBOUNCE_CYCLES);

    localparam int K_INC = 0;
    localparam int K_DEC = 1;
    localparam int K_LOAD = 2;
    localparam int K_CLR = 3;

    logic [3:0]  sync1_r;
    logic [3:0]  sync2_r;
    logic [1:0]  state_r  [4];
    logic [1:0]  state_s  [4];
    logic [19:0] count_r  [4];
    logic [19:0] count_s  [4];
    logic [3:0]  press_r;
    logic [3:0]  press_s;
    logic [3:0]  level_r;
    logic [3:0]  number_r;
    logic        changed_r;

    // two-flop synchronizer; idles high so a reset never looks like a press
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 4'hF;
            sync2_r <= 4'hF;
        end else begin
            sync1_r <= key_n;
            sync2_r <= sync1_r;
        end
    end

    // next-state logic of the per-key debounce FSMs
    always_comb begin
        press_s = 4'h0;
        for (int i = 0; i < 4; i++) begin
            state_s[i] = state_r[i];
            count_s[i] = count_r[i];
            case (state_r[i])
                ST_RELEASED: begin
                    if (!sync2_r[i]) begin
                        state_s[i] = ST_PRESS_WAIT;
                        count_s[i] = 20'd1;
                    end else begin
                        count_s[i] = 20'd0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (sync2_r[i]) begin
                        state_s[i] = ST_RELEASED;
                        count_s[i] = 20'd0;
                    end else if (count_r[i] + 20'd1 >= DB_LIMIT) begin
                        state_s[i] = ST_PRESSED;
                        count_s[i] = 20'd0;
                        press_s[i] = 1'b1;
                    end else begin
                        count_s[i] = count_r[i] + 20'd1;
                    end
                end
                ST_PRESSED: begin
                    if (sync2_r[i]) begin
                        state_s[i] = ST_RELEASE_WAIT;
                        count_s[i] = 20'd1;
                    end else begin
                        count_s[i] = 20'd0;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (!sync2_r[i]) begin
                        state_s[i] = ST_PRESSED;
                        count_s[i] = 20'd0;
                    end else if (count_r[i] + 20'd1 >= DB_LIMIT) begin
                        state_s[i] = ST_RELEASED;
                        count_s[i] = 20'd0;
                    end else begin
                        count_s[i] = count_r[i] + 20'd1;
                    end
                end
                default: begin
                    state_s[i] = ST_RELEASED;
                    count_s[i] = 20'd0;
                end
            endcase
        end
    end

    // debounce state, press pulses and the registered level for the LEDs
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                state_r[i] <= ST_RELEASED;
                count_r[i] <= 20'd0;
            end
            press_r <= 4'h0;
            level_r <= 4'h0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_r[i] <= state_s[i];
                count_r[i] <= count_s[i];
                level_r[i] <= (state_s[i] == ST_PRESSED) || (state_s[i] == ST_RELEASE_WAIT);
            end
            press_r <= press_s;
        end
    end

    // apply the highest-priority pending action; lower-priority pulses are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            number_r  <= 4'h0;
            changed_r <= 1'b0;
        end else begin
            changed_r <= |press_r;
            if (press_r[K_CLR]) begin
                number_r <= 4'h0;
            end else if (press_r[K_LOAD]) begin
                number_r <= sw;
            end else if (press_r[K_INC]) begin
                number_r <= number_r + 4'd1;
            end else if (press_r[K_DEC]) begin
                number_r <= number_r - 4'd1;
            end else begin
                number_r <= number_r;
            end
        end
    end

    assign number    = number_r;
    assign changed   = changed_r;
    assign key_level = level_r;

endmodule

// File: tb/tb_digit_entry.sv
// Bench for digit_entry with DEBOUNCE_CYCLES=4: a run-length debounce model checked every cycle,
// plus directed scenarios with hand-computed results.
module tb_digit_entry;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] key_n = 4'hF;
    logic [3:0] sw = 4'h0;
    logic [3:0] number;
    logic       changed;
    logic [3:0] key_level;

    digit_entry #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_n     (key_n),
        .sw        (sw),
        .number    (number),
        .changed   (changed),
        .key_level (key_level)
    );

    always #5 clk = ~clk;

    // h1/h2: raw keys seen one and two edges ago; run: consecutive samples disagreeing with lvl
    typedef struct packed {
        logic [3:0]       h1;
        logic [3:0]       h2;
        logic [3:0]       lvl;
        logic [3:0]       pulse;
        logic [3:0]       number;
        logic             changed;
        logic [3:0][20:0] run;
    } model_t;

    model_t mdl;
    int     vectors = 0;
    int     errors = 0;
    bit     chk_en = 1'b0;

    function automatic model_t model_step(model_t m, logic rst, logic [3:0] kn, logic [3:0] sv);
        model_t     n = m;
        logic [3:0] s;
        if (rst) begin
            n = '0;
            n.h1 = 4'hF;
            n.h2 = 4'hF;
            return n;
        end
        s = m.h2;
        n.h2 = m.h1;
        n.h1 = kn;
        n.changed = |m.pulse;
        if (m.pulse[3])      n.number = 4'd0;
        else if (m.pulse[2]) n.number = sv;
        else if (m.pulse[0]) n.number = m.number + 4'd1;
        else if (m.pulse[1]) n.number = m.number - 4'd1;
        n.pulse = 4'h0;
        for (int i = 0; i < 4; i++) begin
            if ((~s[i]) == n.lvl[i]) begin
                n.run[i] = 21'd0;
            end else begin
                n.run[i] = n.run[i] + 21'd1;
                if (n.run[i] == 21'(DB)) begin
                    n.lvl[i] = ~n.lvl[i];
                    n.run[i] = 21'd0;
                    n.pulse[i] = n.lvl[i];
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk) mdl <= model_step(mdl, reset, key_n, sw);

    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if ({number, changed, key_level} !== {mdl.number, mdl.changed, mdl.lvl}) begin
                errors++;
                $display("FAIL model t=%0t: number=%h changed=%b key_level=%b, expected number=%h changed=%b key_level=%b",
                         $time, number, changed, key_level, mdl.number, mdl.changed, mdl.lvl);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // hold the keys in mask pressed for ten cycles, release, and count changed pulses throughout
    task automatic press(input logic [3:0] mask, output int pulses);
        pulses = 0;
        key_n = ~mask;
        repeat (10) begin
            @(negedge clk);
            if (changed) pulses++;
        end
        key_n = 4'hF;
        repeat (10) begin
            @(negedge clk);
            if (changed) pulses++;
        end
    endtask

    int p;
    bit lvl1_seen;

    initial begin
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_number", number, 0);
        check("reset_changed", changed, 0);
        check("reset_level", key_level, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // increment: number updates exactly 7 edges after key_n falls
        key_n = 4'b1110;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 6) begin
                check("inc_early_changed", changed, 0);
                check("inc_early_number", number, 0);
            end
            if (k == 7) begin
                check("inc_changed", changed, 1);
                check("inc_number", number, 1);
            end
        end
        repeat (5) @(negedge clk);
        check("inc_hold_number", number, 1);
        check("inc_hold_changed", changed, 0);
        check("inc_hold_level", key_level, 4'b0001);
        key_n = 4'hF;
        repeat (10) @(negedge clk);
        check("inc_release_level", key_level, 0);

        // 3-cycle glitch on decrement must be ignored
        key_n = 4'b1101;
        repeat (3) @(negedge clk);
        key_n = 4'hF;
        p = 0;
        lvl1_seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (changed) p++;
            if (key_level[1]) lvl1_seen = 1'b1;
        end
        check("glitch_pulses", p, 0);
        check("glitch_number", number, 1);
        check("glitch_level", int'(lvl1_seen), 0);

        // wrap-around in both directions
        press(4'b1000, p);
        check("clear_number", number, 0);
        check("clear_pulses", p, 1);
        press(4'b0010, p);
        check("dec_wrap_number", number, 15);
        check("dec_wrap_pulses", p, 1);
        press(4'b0001, p);
        check("inc_wrap_number", number, 0);
        check("inc_wrap_pulses", p, 1);

        // load beats increment when both fall together
        sw = 4'hA;
        press(4'b0101, p);
        check("prio_number", number, 10);
        check("prio_pulses", p, 1);

        // clear while already 0 still pulses
        press(4'b1000, p);
        check("clear_zero_pulses", p, 1);

        // reset mid-debounce of clear, key still held afterwards
        sw = 4'h5;
        press(4'b0100, p);
        check("load5_number", number, 5);
        key_n = 4'b0111;
        repeat (4) @(negedge clk);
        check("pre_reset_number", number, 5);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("in_reset_number", number, 0);
        check("in_reset_changed", changed, 0);
        check("in_reset_level", key_level, 0);
        reset = 1'b0;
        p = 0;
        repeat (12) begin
            @(negedge clk);
            if (changed) p++;
        end
        check("post_reset_pulses", p, 1);
        check("post_reset_number", number, 0);
        check("post_reset_level", key_level, 4'b1000);
        key_n = 4'hF;
        repeat (10) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/digit_entry.md
DIGIT_ENTRY -- requirements
Module: digit_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 240000 (10 ms at 24 MHz): consecutive stable samples required to accept a key level change; legal range 2..2^20-1.
REQ-002 SHALL have port clk, input, 1, the single clock for all logic.
REQ-003 SHALL have port reset, input, 1; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port key_n, input, 4, raw asynchronous pushbuttons, active-low: [0] increment, [1] decrement, [2] load sw, [3] clear.
REQ-005 SHALL have port sw, input, 4, slide-switch value used by load, assumed quasi-static.
REQ-006 SHALL have port number, output, 4, current digit value that feeds the seven-segment display stage.
REQ-007 SHALL have port changed, output, 1, one-cycle pulse coincident with each applied action.
REQ-008 SHALL have port key_level, output, 4, debounced key state, 1 = pressed, for LED monitoring.

Function
REQ-009 SHALL pass each key_n bit through a two-flop synchronizer before any other use.
REQ-010 SHALL run one independent debounce FSM per key with states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT, plus a per-key counter of at least 20 bits.
REQ-011 RELEASED: a synchronized low sample moves the FSM to PRESS_WAIT with count=1. A high sample keeps it in RELEASED.
REQ-012 PRESS_WAIT: each low sample increments count. When count reaches DEBOUNCE_CYCLES, the FSM moves to PRESSED and asserts the internal press pulse for exactly that cycle. Any high sample returns it to RELEASED with count=0 and no pulse.
REQ-013 PRESSED/RELEASE_WAIT SHALL mirror REQ-011/012 with the levels inverted. Acceptance of the release produces no pulse.
REQ-014 key_level[i] SHALL be 1 in PRESSED and RELEASE_WAIT, and 0 in RELEASED and PRESS_WAIT.
REQ-015 A key held continuously SHALL produce exactly one press pulse: no auto-repeat.
REQ-016 On the clock edge after a press pulse, number SHALL update and changed SHALL be 1 for that one cycle.
REQ-017 Latency from the first low key_n level sampled by the synchronizer to the updated number SHALL be exactly DEBOUNCE_CYCLES+3 clk edges.
REQ-018 Actions: clear → 0; load → sw; increment → number+1 mod 16 (15 wraps to 0); decrement → number-1 mod 16 (0 wraps to 15).
REQ-019 Simultaneous press pulses in one cycle SHALL apply only the highest-priority action, in the order clear > load > increment > decrement. Exactly one changed pulse is produced and the lower-priority pulses are discarded.
REQ-020 changed SHALL pulse whenever an action is applied, even if the value does not change (e.g. clear while already 0).
REQ-021 number SHALL hold its value in all cycles without an applied action.
REQ-022 The block SHALL contain no combinational path from key_n or sw to any output. All outputs are registered.

Reset
REQ-023 While reset=1 at a clk edge: number=0, changed=0, key_level=0, every FSM in RELEASED, every counter 0, every synchronizer flop 1.
REQ-024 Reset asserted mid-debounce or mid-press SHALL abort without a pulse. A key still held after reset deasserts SHALL be debounced afresh and generate one press pulse.
REQ-025 reset SHALL take priority over any same-cycle press pulse.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 Reset, then hold key_n[0]=0 → number 0→1 and changed=1 exactly 7 edges after key_n falls. Number stays 1 while held; key_level[0]=1.
REQ-027 Glitch key_n[1] low for 3 cycles, then high → no changed pulse, number unchanged, key_level[1] stays 0.
REQ-028 From number=0, press decrement → 15. From 15, press increment → 0. Each press produces one changed pulse.
REQ-029 sw=4'hA, with key_n[2] and key_n[0] falling in the same cycle → number=A (not B) and a single changed pulse.
REQ-030 Assert reset during PRESS_WAIT of key 3 with number=5, keep the key held → number=0 during reset. After reset deasserts, a fresh debounce produces a clear and one changed pulse.
